mem_arbiter: RTL

Two-requester arbiter and sequencer for the shared single-port data/program RAM behind the microprogrammable CPU. It grants the RAM either to the CPU memory port (requester 0) or to the I/O / program-loader port (requester 1) with round-robin fairness. It sequences each access as a fixed four-state transaction (issue, wait, respond) and returns read data plus a one-cycle acknowledge to the winner.

---
 rtl/mem_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter and fixed 4-state sequencer for a shared synchronous RAM.
// Optional grant locking (i_w_lock0/1) is compiled in when MEM_ARB_LOCK_EN is defined.
module mem_arbiter #(
  parameter int p_data_width    = 16,
  parameter int p_address_width = 10
) (
  input  logic                       i_w_clk,
  input  logic                       i_w_reset,
  input  logic                       i_w_req0,
  input  logic                       i_w_req1,
  input  logic                       i_w_we0,
  input  logic                       i_w_we1,
  input  logic [p_address_width-1:0] i_w_addr0,
  input  logic [p_address_width-1:0] i_w_addr1,
  input  logic [p_data_width-1:0]    i_w_wdata0,
  input  logic [p_data_width-1:0]    i_w_wdata1,
  input  logic                       i_w_lock0,
  input  logic                       i_w_lock1,
  output logic                       o_w_ack0,
  output logic                       o_w_ack1,
  output logic [p_data_width-1:0]    o_w_rdata0,
  output logic [p_data_width-1:0]    o_w_rdata1,
  output logic [1:0]                 o_w_grant,
  output logic                       o_w_mem_cs,
  output logic                       o_w_mem_we,
  output logic [p_address_width-1:0] o_w_mem_addr,
  output logic [p_data_width-1:0]    o_w_mem_wdata,
  input  logic [p_data_width-1:0]    i_w_mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                     r_state, w_state_nxt;
  logic                       r_last, w_last_nxt;
  logic [1:0]                 r_ack, w_ack_nxt;
  logic [1:0]                 r_grant, w_grant_nxt;
  logic                       r_mem_cs, w_mem_cs_nxt;
  logic                       r_mem_we, w_mem_we_nxt;
  logic [p_address_width-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [p_data_width-1:0]    r_mem_wdata, w_mem_wdata_nxt;
  logic [p_data_width-1:0]    r_rdata0, w_rdata0_nxt;
  logic [p_data_width-1:0]    r_rdata1, w_rdata1_nxt;
  logic                       w_go;
  logic                       w_win;
  logic                       w_locked;
  logic [1:0]                 w_req;

  assign w_req = {i_w_req1, i_w_req0};

`ifdef MEM_ARB_LOCK_EN
  logic       r_lock, w_lock_nxt;
  logic [1:0] w_lock_in;

  assign w_lock_in = {i_w_lock1, i_w_lock0};
  // r_last is always the owner of the most recent transaction, i.e. the lock holder.
  assign w_locked  = r_lock & w_req[r_last];

  // Lock follows the owner's lock input on RESP entry and drops once the owner stops requesting.
  always_comb begin
    w_lock_nxt = r_lock;
    if (r_state == ST_WAIT) begin
      w_lock_nxt = w_lock_in[r_last];
    end else if ((r_state == ST_IDLE) && !w_req[r_last]) begin
      w_lock_nxt = 1'b0;
    end else begin
      w_lock_nxt = r_lock;
    end
  end

  // Lock flag register.
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      r_lock <= 1'b0;
    end else begin
      r_lock <= w_lock_nxt;
    end
  end
`else
  logic w_unused_lock;

  assign w_unused_lock = i_w_lock0 | i_w_lock1;
  assign w_locked      = 1'b0;
`endif

  // Winner selection: a held lock overrides the round-robin pointer.
  always_comb begin
    w_go  = 1'b1;
    w_win = 1'b0;
    if (w_locked) begin
      w_win = r_last;
    end else if (w_req == 2'b11) begin
      w_win = ~r_last;
    end else if (w_req == 2'b10) begin
      w_win = 1'b1;
    end else if (w_req == 2'b01) begin
      w_win = 1'b0;
    end else begin
      w_go = 1'b0;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_ack_nxt       = 2'b00;
    w_grant_nxt     = r_grant;
    w_mem_cs_nxt    = r_mem_cs;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_rdata0_nxt    = r_rdata0;
    w_rdata1_nxt    = r_rdata1;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_state_nxt     = ST_ISSUE;
          w_last_nxt      = w_win;
          w_grant_nxt     = w_win ? 2'b10 : 2'b01;
          w_mem_cs_nxt    = 1'b1;
          w_mem_we_nxt    = w_win ? i_w_we1 : i_w_we0;
          w_mem_addr_nxt  = w_win ? i_w_addr1 : i_w_addr0;
          w_mem_wdata_nxt = w_win ? i_w_wdata1 : i_w_wdata0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt  = ST_WAIT;
        w_mem_cs_nxt = 1'b0;
        w_mem_we_nxt = 1'b0;
      end
      ST_WAIT: begin
        // RAM data is valid now; only the owner's read register is touched.
        w_state_nxt = ST_RESP;
        w_ack_nxt   = r_grant;
        if (r_last) begin
          w_rdata1_nxt = i_w_mem_rdata;
        end else begin
          w_rdata0_nxt = i_w_mem_rdata;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 2'b00;
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_grant_nxt  = 2'b00;
        w_mem_cs_nxt = 1'b0;
        w_mem_we_nxt = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output and pointer registers.
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      r_last      <= 1'b1;
      r_ack       <= 2'b00;
      r_grant     <= 2'b00;
      r_mem_cs    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {p_address_width{1'b0}};
      r_mem_wdata <= {p_data_width{1'b0}};
      r_rdata0    <= {p_data_width{1'b0}};
      r_rdata1    <= {p_data_width{1'b0}};
    end else begin
      r_last      <= w_last_nxt;
      r_ack       <= w_ack_nxt;
      r_grant     <= w_grant_nxt;
      r_mem_cs    <= w_mem_cs_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_rdata0    <= w_rdata0_nxt;
      r_rdata1    <= w_rdata1_nxt;
    end
  end

  assign o_w_ack0      = r_ack[0];
  assign o_w_ack1      = r_ack[1];
  assign o_w_grant     = r_grant;
  assign o_w_mem_cs    = r_mem_cs;
  assign o_w_mem_we    = r_mem_we;
  assign o_w_mem_addr  = r_mem_addr;
  assign o_w_mem_wdata = r_mem_wdata;
  assign o_w_rdata0    = r_rdata0;
  assign o_w_rdata1    = r_rdata1;

endmodule
